// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches words over a req/gnt/rvalid
// memory handshake and hands them to decode over a valid/ready handshake.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        br_taken,
  input  logic [31:0] br_target
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic [31:0] r_pc_plus4;
  logic        r_ir_valid;
  logic [31:0] w_pc_inc;
  logic [31:0] w_br_pc;
  logic        w_capture;
  logic        w_accept;
  logic        w_unused;

  assign w_pc_inc  = r_pc + 32'd4;
  assign w_br_pc   = {br_target[31:2], 2'b00};
  assign w_unused  = ^br_target[1:0];
  assign w_capture = (r_state == S_WAIT) && imem_rvalid && !br_taken;
  assign w_accept  = (r_state == S_HOLD) && ir_ready && !br_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A redirect always wins; a granted or outstanding fetch must drain first.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_REQ: begin
        if (imem_gnt) begin
          w_next_state = br_taken ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (br_taken) begin
          w_next_state = imem_rvalid ? S_REQ : S_DRAIN;
        end else if (imem_rvalid) begin
          w_next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (br_taken || ir_ready) begin
          w_next_state = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) begin
          w_next_state = S_REQ;
        end
      end
      default: w_next_state = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
      r_pc_out   <= 32'd0;
      r_pc_plus4 <= 32'd0;
      r_ir_valid <= 1'b0;
    end else begin
      if (br_taken) begin
        r_pc <= w_br_pc;
      end else if (w_capture) begin
        r_pc <= w_pc_inc;
      end

      if (w_capture) begin
        r_instr    <= imem_rdata;
        r_pc_out   <= r_pc;
        r_pc_plus4 <= w_pc_inc;
      end

      if (br_taken || w_accept) begin
        r_ir_valid <= 1'b0;
      end else if (w_capture) begin
        r_ir_valid <= 1'b1;
      end
    end
  end

  assign imem_req  = (r_state == S_REQ) && !rst;
  assign imem_addr = r_pc;
  assign ir_valid  = r_ir_valid;
  assign instr     = r_instr;
  assign op        = r_instr[31:26];
  assign pc_out    = r_pc_out;
  assign pc_plus4  = r_pc_plus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a scripted memory responder plus
// an output scoreboard of expected {pc, instr} pairs.
module tb_instr_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        irValid;
  logic        irReady;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] pcOut;
  logic [31:0] pcPlus4;
  logic        brTaken;
  logic [31:0] brTarget;

  logic        rst2;
  logic        req2;
  logic [31:0] addr2;
  logic        gnt2;
  logic        rvalid2;
  logic [31:0] rdata2;
  logic        irValid2;
  logic        ready2;
  logic [31:0] instr2;
  logic [5:0]  op2;
  logic [31:0] pcOut2;
  logic [31:0] pcPlus42;
  logic        brTaken2;
  logic [31:0] brTarget2;

  int   checks;
  int   errors;
  int   gntDelay;
  int   rvLat;
  int   grantsAllowed;
  int   grantsDone;
  exp_t expQ[$];

  instr_fetch_unit u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imemReq), .imem_addr(imemAddr), .imem_gnt(imemGnt),
    .imem_rvalid(imemRvalid), .imem_rdata(imemRdata),
    .ir_valid(irValid), .ir_ready(irReady), .instr(instr), .op(op),
    .pc_out(pcOut), .pc_plus4(pcPlus4),
    .br_taken(brTaken), .br_target(brTarget)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
    .clk(clk), .rst(rst2),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .ir_valid(irValid2), .ir_ready(ready2), .instr(instr2), .op(op2),
    .pc_out(pcOut2), .pc_plus4(pcPlus42),
    .br_taken(brTaken2), .br_target(brTarget2)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'd0) return 32'h8C01_0004;
    return {a[7:2] ^ 6'h2A, a[25:0] ^ 26'h155_5555};
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Memory model: grants after gntDelay requested cycles, answers rvLat cycles
  // after the grant, and only grants while the running test allows it.
  initial begin : memResponder
    int          reqCnt;
    int          waitCnt;
    bit          pending;
    logic [31:0] pendAddr;
    reqCnt = 0; waitCnt = 0; pending = 0; pendAddr = '0;
    imemGnt = 1'b0; imemRvalid = 1'b0; imemRdata = '0;
    forever begin
      @(negedge clk);
      imemGnt = 1'b0;
      imemRvalid = 1'b0;
      if (rst) begin
        pending = 0;
        reqCnt = 0;
      end else if (pending) begin
        if (waitCnt == 0) begin
          imemRvalid = 1'b1;
          imemRdata = memData(pendAddr);
          pending = 0;
        end else begin
          waitCnt--;
        end
      end else if (imemReq === 1'b1 && grantsDone < grantsAllowed) begin
        if (reqCnt >= gntDelay) begin
          imemGnt = 1'b1;
          pending = 1;
          pendAddr = imemAddr;
          waitCnt = rvLat - 1;
          reqCnt = 0;
          grantsDone++;
        end else begin
          reqCnt++;
        end
      end
    end
  end

  // Every decode handshake must match the oldest expected fetch
  initial begin : outMonitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && irValid === 1'b1 && irReady && !brTaken) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_output: got pc_out=%h instr=%h, required no output", pcOut, instr);
        end else begin
          e = expQ.pop_front();
          if (pcOut !== e.pc || instr !== e.word) begin
            errors++;
            $display("[TB] FAIL scoreboard: got pc_out=%h instr=%h, required pc_out=%h instr=%h",
                     pcOut, instr, e.pc, e.word);
          end
        end
      end
    end
  end

  task automatic pushExp(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    e.word = memData(pc);
    expQ.push_back(e);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if (imemReq !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_req: got %b, required 0", imemReq);
    end
    checks++;
    if (irValid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %b, required 0", irValid);
    end
    checks++;
    if ({instr, op, pcOut, pcPlus4} !== '0) begin
      errors++; $display("[TB] FAIL reset_regs: got instr=%h op=%h pc_out=%h pc_plus4=%h, required all 0",
                         instr, op, pcOut, pcPlus4);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'd0) begin
      errors++; $display("[TB] FAIL first_req: got req=%b addr=%h, required req=1 addr=0", imemReq, imemAddr);
    end
    pushExp(32'd0);
    grantsAllowed++;
    for (int i = 0; i < 20 && irValid !== 1'b1; i++) tick;
    checks++;
    if (irValid !== 1'b1) begin
      errors++; $display("[TB] FAIL first_valid_timeout: got %b, required 1", irValid);
    end
    checks++;
    if (op !== 6'h23 || pcOut !== 32'd0 || pcPlus4 !== 32'd4) begin
      errors++; $display("[TB] FAIL first_fields: got op=%h pc_out=%h pc_plus4=%h, required op=23 pc_out=0 pc_plus4=4",
                         op, pcOut, pcPlus4);
    end
    irReady = 1'b1;
    tick;
    irReady = 1'b0;
    checks++;
    if (irValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'd4) begin
      errors++; $display("[TB] FAIL next_fetch: got valid=%b req=%b addr=%h, required valid=0 req=1 addr=4",
                         irValid, imemReq, imemAddr);
    end
  endtask

  task automatic test_back_to_back;
    pushExp(32'd4);
    grantsAllowed++;
    irReady = 1'b1;
    tick;
    checks++;
    if (imemReq !== 1'b0) begin
      errors++; $display("[TB] FAIL no_prefetch: got req=%b, required 0", imemReq);
    end
    tick;
    tick;
    irReady = 1'b0;
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'd8) begin
      errors++; $display("[TB] FAIL three_cycle_loop: got req=%b addr=%h, required req=1 addr=8", imemReq, imemAddr);
    end
  endtask

  task automatic test_gnt_delay;
    int ticks;
    bit bad;
    ticks = 0;
    bad = 0;
    gntDelay = 3;
    rvLat = 4;
    pushExp(32'd8);
    grantsAllowed++;
    while (irValid !== 1'b1 && ticks < 30) begin
      if (imemReq === 1'b1 && imemAddr !== 32'd8) bad = 1;
      if (ticks < 4 && imemReq !== 1'b1) bad = 1;
      if (ticks >= 4 && imemReq !== 1'b0) bad = 1;
      tick;
      ticks++;
    end
    checks++;
    if (bad) begin
      errors++; $display("[TB] FAIL gnt_delay_addr: got unstable req/addr, required req=1 addr=8 until grant");
    end
    checks++;
    if (ticks != 8) begin
      errors++; $display("[TB] FAIL gnt_delay_latency: got %0d cycles, required 8", ticks);
    end
    gntDelay = 0;
    rvLat = 1;
  endtask

  task automatic test_hold_stall;
    bit bad;
    bad = 0;
    irReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (irValid !== 1'b1 || instr !== memData(32'd8) || pcOut !== 32'd8 || imemReq !== 1'b0) bad = 1;
      tick;
    end
    checks++;
    if (bad) begin
      errors++; $display("[TB] FAIL hold_stable: got valid=%b instr=%h pc_out=%h req=%b, required 1 %h 8 0",
                         irValid, instr, pcOut, imemReq, memData(32'd8));
    end
    irReady = 1'b1;
    tick;
    irReady = 1'b0;
    checks++;
    if (irValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'd12) begin
      errors++; $display("[TB] FAIL hold_release: got valid=%b req=%b addr=%h, required 0 1 0000000c",
                         irValid, imemReq, imemAddr);
    end
  endtask

  task automatic test_branch_wait;
    bit bad;
    bad = 0;
    rvLat = 3;
    grantsAllowed++;
    for (int i = 0; i < 10 && imemReq !== 1'b0; i++) tick;
    brTaken = 1'b1;
    brTarget = 32'h0000_0103;
    tick;
    brTaken = 1'b0;
    checks++;
    if (imemReq !== 1'b0 || irValid !== 1'b0) begin
      errors++; $display("[TB] FAIL branch_drain: got req=%b valid=%b, required 0 0", imemReq, irValid);
    end
    rvLat = 1;
    pushExp(32'h0000_0100);
    grantsAllowed++;
    for (int i = 0; i < 10 && imemReq !== 1'b1; i++) begin
      if (irValid !== 1'b0) bad = 1;
      tick;
    end
    checks++;
    if (bad || imemReq !== 1'b1 || imemAddr !== 32'h0000_0100) begin
      errors++; $display("[TB] FAIL branch_target: got req=%b addr=%h stale=%b, required req=1 addr=00000100 stale=0",
                         imemReq, imemAddr, bad);
    end
    for (int i = 0; i < 10 && irValid !== 1'b1; i++) tick;
    checks++;
    if (irValid !== 1'b1 || pcOut !== 32'h0000_0100) begin
      errors++; $display("[TB] FAIL branch_fetch: got valid=%b pc_out=%h, required 1 00000100", irValid, pcOut);
    end
    irReady = 1'b1;
    tick;
    irReady = 1'b0;
  endtask

  task automatic test_branch_hold;
    grantsAllowed++;
    for (int i = 0; i < 10 && irValid !== 1'b1; i++) tick;
    irReady = 1'b1;
    brTaken = 1'b1;
    brTarget = 32'h0000_0200;
    tick;
    irReady = 1'b0;
    brTaken = 1'b0;
    checks++;
    if (irValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h0000_0200) begin
      errors++; $display("[TB] FAIL branch_hold: got valid=%b req=%b addr=%h, required 0 1 00000200",
                         irValid, imemReq, imemAddr);
    end
  endtask

  task automatic test_branch_gnt;
    grantsAllowed++;
    brTaken = 1'b1;
    brTarget = 32'h0000_0300;
    tick;
    brTaken = 1'b0;
    checks++;
    if (imemReq !== 1'b0 || imemAddr !== 32'h0000_0300) begin
      errors++; $display("[TB] FAIL branch_gnt: got req=%b addr=%h, required 0 00000300", imemReq, imemAddr);
    end
    pushExp(32'h0000_0300);
    grantsAllowed++;
    for (int i = 0; i < 10 && irValid !== 1'b1; i++) tick;
    checks++;
    if (irValid !== 1'b1 || pcOut !== 32'h0000_0300 || instr !== memData(32'h0000_0300)) begin
      errors++; $display("[TB] FAIL branch_gnt_fetch: got valid=%b pc_out=%h instr=%h, required 1 00000300 %h",
                         irValid, pcOut, instr, memData(32'h0000_0300));
    end
    irReady = 1'b1;
    tick;
    irReady = 1'b0;
  endtask

  task automatic test_reset_pc;
    rst2 = 1'b0;
    #1;
    checks++;
    if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin
      errors++; $display("[TB] FAIL wrap_first_req: got req=%b addr=%h, required 1 fffffffc", req2, addr2);
    end
    gnt2 = 1'b1;
    tick;
    gnt2 = 1'b0;
    rvalid2 = 1'b1;
    rdata2 = 32'h2408_0005;
    tick;
    rvalid2 = 1'b0;
    checks++;
    if (irValid2 !== 1'b1 || pcOut2 !== 32'hFFFF_FFFC || pcPlus42 !== 32'd0 || op2 !== 6'h09) begin
      errors++; $display("[TB] FAIL wrap_fields: got valid=%b pc_out=%h pc_plus4=%h op=%h, required 1 fffffffc 0 09",
                         irValid2, pcOut2, pcPlus42, op2);
    end
    ready2 = 1'b1;
    tick;
    ready2 = 1'b0;
    checks++;
    if (req2 !== 1'b1 || addr2 !== 32'd0) begin
      errors++; $display("[TB] FAIL wrap_next: got req=%b addr=%h, required 1 0", req2, addr2);
    end
    gnt2 = 1'b1;
    tick;
    gnt2 = 1'b0;
    rvalid2 = 1'b1;
    rdata2 = 32'h0000_1234;
    rst2 = 1'b1;
    tick;
    rvalid2 = 1'b0;
    checks++;
    if (irValid2 !== 1'b0 || req2 !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_in_wait: got valid=%b req=%b, required 0 0", irValid2, req2);
    end
    rst2 = 1'b0;
    #1;
    checks++;
    if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin
      errors++; $display("[TB] FAIL reset_pc_restore: got req=%b addr=%h, required 1 fffffffc", req2, addr2);
    end
    rvalid2 = 1'b1;
    tick;
    rvalid2 = 1'b0;
    checks++;
    if (irValid2 !== 1'b0 || req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin
      errors++; $display("[TB] FAIL rvalid_in_req: got valid=%b req=%b addr=%h, required 0 1 fffffffc",
                         irValid2, req2, addr2);
    end
  endtask

  // Scenario sequence followed by the final scoreboard drain check
  initial begin
    checks = 0; errors = 0;
    gntDelay = 0; rvLat = 1; grantsAllowed = 0; grantsDone = 0;
    rst = 1'b1; irReady = 1'b0; brTaken = 1'b0; brTarget = '0;
    rst2 = 1'b1; gnt2 = 1'b0; rvalid2 = 1'b0; rdata2 = '0; ready2 = 1'b0;
    brTaken2 = 1'b0; brTarget2 = '0;
    test_reset;
    test_back_to_back;
    test_gnt_delay;
    test_hold_stall;
    test_branch_wait;
    test_branch_hold;
    test_branch_gnt;
    test_reset_pc;
    tick;
    checks++;
    if (expQ.size() != 0) begin
      errors++; $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
